ws2812b_frame_controller: RTL and testbench

WS2812B_FRAME_CONTROLLER -- requirements
Module: ws2812b_frame_controller

---
 rtl/ws2812b_frame_controller_if.sv | 27 ++
 rtl/ws2812b_frame_controller.sv | 180 ++++++++++++++++++
 tb/tb_ws2812b_frame_controller.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_frame_controller_if.sv
// Bus bundle between the WS2812B frame controller and its environment.
interface ws2812b_frame_controller_if;
    logic        enable;
    logic        din;
    logic        bit_valid;
    logic        bit_value;
    logic [7:0]  pixel_index;
    logic [15:0] latch_cycles;
    logic [23:0] pixel_data;
    logic        pixel_ready;
    logic        frame_done;
    logic [7:0]  frame_pixels;
    logic        frame_error;
    logic        busy;

    // Environment side: drives the line, decoded bits and configuration.
    modport master (
        output enable, din, bit_valid, bit_value, pixel_index, latch_cycles,
        input  pixel_data, pixel_ready, frame_done, frame_pixels, frame_error, busy
    );

    // Controller side.
    modport slave (
        input  enable, din, bit_valid, bit_value, pixel_index, latch_cycles,
        output pixel_data, pixel_ready, frame_done, frame_pixels, frame_error, busy
    );
endinterface

// File: rtl/ws2812b_frame_controller.sv
// WS2812B frame controller: detects latch gaps on the raw line, assembles
// decoded bits into 24-bit GRB words and captures one selected word per frame.
module ws2812b_frame_controller (
    input  logic                        clk,
    input  logic                        reset,
    ws2812b_frame_controller_if.slave   bus
);
    localparam int unsigned WORD_W = 24;
    localparam int unsigned GAP_W  = 16;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned BIT_W  = 5;

    localparam logic [1:0] ST_WAIT_LATCH = 2'd0;
    localparam logic [1:0] ST_IDLE       = 2'd1;
    localparam logic [1:0] ST_RECEIVE    = 2'd2;

    logic               din_meta_q, din_meta_d;
    logic               din_sync_q, din_sync_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [WORD_W-1:0]  pixel_data_q, pixel_data_d;
    logic               pixel_ready_q, pixel_ready_d;
    logic               frame_done_q, frame_done_d;
    logic [IDX_W-1:0]   frame_pixels_q, frame_pixels_d;
    logic               frame_error_q, frame_error_d;
    logic               busy_q, busy_d;

    logic [GAP_W-1:0]   threshold_c;
    logic               gap_hit_c;
    logic [WORD_W-1:0]  acc_shift_c;
    logic               acc_word_done_c;
    logic [BIT_W-1:0]   acc_bit_c;
    logic [IDX_W-1:0]   acc_word_c;
    logic               acc_capture_c;
    logic               take_bit_c;
    logic               end_frame_c;
    logic [BIT_W-1:0]   bit_now_c;
    logic [IDX_W-1:0]   word_now_c;

    // Line synchronizer and saturating low-run (gap) counter.
    always_comb begin
        din_meta_d  = bus.din;
        din_sync_d  = din_meta_q;
        threshold_c = (bus.latch_cycles == '0) ? GAP_W'(1) : bus.latch_cycles;
        gap_hit_c   = (gap_q >= threshold_c);
        if (din_sync_q) begin
            gap_d = '0;
        end else if (gap_q != {GAP_W{1'b1}}) begin
            gap_d = gap_q + GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end
    end

    // Counter and shift values that result if the current bit is accepted.
    always_comb begin
        acc_shift_c     = {shift_q[WORD_W-2:0], bus.bit_value};
        acc_word_done_c = (bit_cnt_q == BIT_W'(WORD_W - 1));
        acc_bit_c       = acc_word_done_c ? '0 : bit_cnt_q + BIT_W'(1);
        acc_capture_c   = acc_word_done_c && (word_cnt_q == bus.pixel_index);
        if (acc_word_done_c && (word_cnt_q != {IDX_W{1'b1}})) begin
            acc_word_c = word_cnt_q + IDX_W'(1);
        end else begin
            acc_word_c = word_cnt_q;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        word_cnt_d     = word_cnt_q;
        shift_d        = shift_q;
        pixel_data_d   = pixel_data_q;
        pixel_ready_d  = 1'b0;
        frame_done_d   = 1'b0;
        frame_pixels_d = frame_pixels_q;
        frame_error_d  = frame_error_q;
        take_bit_c     = 1'b0;
        end_frame_c    = 1'b0;

        if (!bus.enable) begin
            // Abort: discard the partial frame, keep the reported results.
            state_d    = ST_WAIT_LATCH;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            shift_d    = '0;
        end else begin
            case (state_q)
                ST_WAIT_LATCH: begin
                    if (gap_hit_c) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.bit_valid) begin
                        take_bit_c = 1'b1;
                        state_d    = ST_RECEIVE;
                    end
                end
                ST_RECEIVE: begin
                    take_bit_c  = bus.bit_valid;
                    end_frame_c = gap_hit_c;
                end
                default: begin
                    state_d = ST_WAIT_LATCH;
                end
            endcase
        end

        bit_now_c  = take_bit_c ? acc_bit_c  : bit_cnt_q;
        word_now_c = take_bit_c ? acc_word_c : word_cnt_q;

        if (take_bit_c) begin
            shift_d    = acc_shift_c;
            bit_cnt_d  = acc_bit_c;
            word_cnt_d = acc_word_c;
            if (acc_capture_c) begin
                pixel_data_d  = acc_shift_c;
                pixel_ready_d = 1'b1;
            end
        end

        // A bit arriving with the gap is counted before the frame closes.
        if (end_frame_c) begin
            state_d        = ST_IDLE;
            frame_done_d   = 1'b1;
            frame_pixels_d = word_now_c;
            frame_error_d  = (bit_now_c != '0);
            bit_cnt_d      = '0;
            word_cnt_d     = '0;
            shift_d        = '0;
        end

        busy_d = (state_d == ST_RECEIVE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_meta_q     <= 1'b0;
            din_sync_q     <= 1'b0;
            gap_q          <= '0;
            state_q        <= ST_WAIT_LATCH;
            bit_cnt_q      <= '0;
            word_cnt_q     <= '0;
            shift_q        <= '0;
            pixel_data_q   <= '0;
            pixel_ready_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            frame_error_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            din_meta_q     <= din_meta_d;
            din_sync_q     <= din_sync_d;
            gap_q          <= gap_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            word_cnt_q     <= word_cnt_d;
            shift_q        <= shift_d;
            pixel_data_q   <= pixel_data_d;
            pixel_ready_q  <= pixel_ready_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            frame_error_q  <= frame_error_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.pixel_data   = pixel_data_q;
    assign bus.pixel_ready  = pixel_ready_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.frame_pixels = frame_pixels_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_ws2812b_frame_controller.sv
// Bench for ws2812b_frame_controller: frame-level model plus directed frames.
module tb_ws2812b_frame_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;

    ws2812b_frame_controller_if bus ();

    ws2812b_frame_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rdy_cnt  = 0;
    int done_cnt = 0;

    // Model: frame contents are kept as a queue of received bits.
    bit          mq[$];
    int          m_mode = 0;      // 0 waiting for latch, 1 idle, 2 in frame
    int          m_gap  = 0;
    bit          m_d1 = 1'b0, m_d2 = 1'b0;
    int          m_thr;
    bit          m_hit;
    bit          m_take;
    int          m_n;
    logic [23:0] m_w;
    logic [23:0] e_data  = '0;
    logic        e_ready = 1'b0;
    logic        e_done  = 1'b0;
    logic [7:0]  e_pix   = '0;
    logic        e_err   = 1'b0;
    logic        e_busy  = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_mode = 0; m_gap = 0; m_d1 = 1'b0; m_d2 = 1'b0;
            e_data = '0; e_ready = 1'b0; e_done = 1'b0;
            e_pix = '0; e_err = 1'b0; e_busy = 1'b0;
        end else begin
            m_thr   = (bus.latch_cycles == 16'd0) ? 1 : int'(bus.latch_cycles);
            m_hit   = (m_gap >= m_thr);
            e_ready = 1'b0;
            e_done  = 1'b0;
            m_take  = 1'b0;
            if (!bus.enable) begin
                m_mode = 0;
                mq.delete();
            end else if (m_mode == 0) begin
                if (m_hit) m_mode = 1;
            end else if (m_mode == 1) begin
                if (bus.bit_valid) begin
                    m_take = 1'b1;
                    m_mode = 2;
                end
            end else begin
                m_take = bus.bit_valid;
            end
            if (m_take) begin
                mq.push_back(bus.bit_value);
                m_n = mq.size();
                if ((m_n % 24) == 0 && (m_n / 24 - 1) == int'(bus.pixel_index)) begin
                    m_w = '0;
                    for (int k = m_n - 24; k < m_n; k++) m_w = {m_w[22:0], mq[k]};
                    e_data  = m_w;
                    e_ready = 1'b1;
                end
            end
            if (bus.enable && m_mode == 2 && m_hit) begin
                m_n    = mq.size();
                e_done = 1'b1;
                e_pix  = (m_n / 24 > 255) ? 8'd255 : 8'(m_n / 24);
                e_err  = ((m_n % 24) != 0);
                mq.delete();
                m_mode = 1;
            end
            e_busy = (m_mode == 2);
            m_gap  = m_d2 ? 0 : ((m_gap == 65535) ? 65535 : m_gap + 1);
            m_d2   = m_d1;
            m_d1   = bus.din;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pre();
        bus.din = 1'b1;
        repeat (3) tick();
    endtask

    task automatic gap(input int n);
        bus.din = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        bus.bit_valid = 1'b1;
        bus.bit_value = b;
        tick();
        bus.bit_valid = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    int r0, d0;

    initial begin
        bus.enable = 1'b0; bus.din = 1'b0; bus.bit_valid = 1'b0; bus.bit_value = 1'b0;
        bus.pixel_index = 8'd0; bus.latch_cycles = 16'd50;
        fork
            begin : compare_loop
                forever begin
                    @(negedge clk);
                    rdy_cnt  += int'(bus.pixel_ready);
                    done_cnt += int'(bus.frame_done);
                    chk("pixel_data",   32'(bus.pixel_data),   32'(e_data));
                    chk("pixel_ready",  32'(bus.pixel_ready),  32'(e_ready));
                    chk("frame_done",   32'(bus.frame_done),   32'(e_done));
                    chk("frame_pixels", 32'(bus.frame_pixels), 32'(e_pix));
                    chk("frame_error",  32'(bus.frame_error),  32'(e_err));
                    chk("busy",         32'(bus.busy),         32'(e_busy));
                end
            end
            begin : stimulus
                repeat (3) tick();
                reset = 1'b0;
                bus.enable = 1'b1;
                gap(60);
                chk("idle_busy", 32'(bus.busy), 32'd0);
                chk("idle_data", 32'(bus.pixel_data), 32'd0);
                chk("idle_pix",  32'(bus.frame_pixels), 32'd0);
                chk("idle_err",  32'(bus.frame_error), 32'd0);

                // single word
                r0 = rdy_cnt; d0 = done_cnt;
                pre(); send_word(24'hFF8001); gap(60);
                chk("w1_data",  32'(bus.pixel_data), 32'hFF8001);
                chk("w1_ready", 32'(rdy_cnt - r0), 32'd1);
                chk("w1_done",  32'(done_cnt - d0), 32'd1);
                chk("w1_pix",   32'(bus.frame_pixels), 32'd1);
                chk("w1_err",   32'(bus.frame_error), 32'd0);

                // four words, capture index 2
                bus.pixel_index = 8'd2;
                r0 = rdy_cnt;
                pre();
                send_word(24'h111111); send_word(24'h222222);
                send_word(24'h333333); send_word(24'h444444);
                gap(60);
                chk("w4_data",  32'(bus.pixel_data), 32'h333333);
                chk("w4_ready", 32'(rdy_cnt - r0), 32'd1);
                chk("w4_pix",   32'(bus.frame_pixels), 32'd4);

                // 30 bits: one word plus a partial
                bus.pixel_index = 8'd0;
                pre(); send_word(24'h0F0F0F);
                for (int i = 0; i < 6; i++) send_bit(i[0]);
                gap(60);
                chk("part_data", 32'(bus.pixel_data), 32'h0F0F0F);
                chk("part_pix",  32'(bus.frame_pixels), 32'd1);
                chk("part_err",  32'(bus.frame_error), 32'd1);
                pre(); send_word(24'h123456); gap(60);
                chk("clean_err",  32'(bus.frame_error), 32'd0);
                chk("clean_data", 32'(bus.pixel_data), 32'h123456);

                // index beyond frame length: no capture
                bus.pixel_index = 8'd5;
                r0 = rdy_cnt;
                pre(); send_word(24'h777777); gap(60);
                chk("oob_ready", 32'(rdy_cnt - r0), 32'd0);
                chk("oob_data",  32'(bus.pixel_data), 32'h123456);

                // enable dropped mid-frame
                bus.pixel_index = 8'd0;
                d0 = done_cnt;
                pre();
                for (int i = 0; i < 12; i++) send_bit(1'b1);
                bus.enable = 1'b0;
                repeat (3) tick();
                bus.enable = 1'b1;
                gap(60);
                chk("abort_done", 32'(done_cnt - d0), 32'd0);
                pre(); send_word(24'hABCDEF); gap(60);
                chk("abort_next_done", 32'(done_cnt - d0), 32'd1);
                chk("abort_next_data", 32'(bus.pixel_data), 32'hABCDEF);

                // asynchronous reset mid-word
                pre();
                for (int i = 0; i < 10; i++) send_bit(1'b1);
                #2 reset = 1'b1;
                #1;
                chk("rst_data", 32'(bus.pixel_data), 32'd0);
                chk("rst_pix",  32'(bus.frame_pixels), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                tick();
                reset = 1'b0;

                // latch_cycles=0 behaves as threshold 1
                bus.latch_cycles = 16'd0;
                d0 = done_cnt;
                gap(3);
                pre(); send_word(24'h5A5A5A);
                gap(6);
                chk("thr0_done", 32'(done_cnt - d0), 32'd1);
                chk("thr0_data", 32'(bus.pixel_data), 32'h5A5A5A);
                chk("thr0_pix",  32'(bus.frame_pixels), 32'd1);
                repeat (2) tick();
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
